// File: rtl/pairwise_cmp_pkg.sv
// Shared types and constants for the pairwise comparison voter.
// Holds the FSM state encoding, size defaults and legacy k-out-of-n presets.
package pairwise_cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam int N_MAX_DEF = 9;
    localparam int DW_DEF    = 64;

    localparam int P2OO2_N   = 2;
    localparam int P2OO2_THR = 2;
    localparam int P2OO3_N   = 3;
    localparam int P2OO3_THR = 2;
    localparam int P4OO7_N   = 7;
    localparam int P4OO7_THR = 4;
    localparam int P5OO9_N   = 9;
    localparam int P5OO9_THR = 5;

endpackage

// File: rtl/pairwise_cmp_seq_pair_seq.sv
// Walks the (i,j) pair indices in lexicographic order, one step per advance.
// Flags the final pair (n-2,n-1) so the voter knows when to stop.
module pair_seq
    import pairwise_cmp_pkg::*;
#(
    parameter int N_MAX = N_MAX_DEF,
    localparam int CW = $clog2(N_MAX),
    localparam int NW = $clog2(N_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_adv,
    input  logic [NW-1:0] i_n,
    output logic [CW-1:0] o_i,
    output logic [CW-1:0] o_j,
    output logic          o_last
);

    logic [CW-1:0] r_i;
    logic [CW-1:0] r_j;
    logic [CW-1:0] w_nm1;
    logic [CW-1:0] w_nm2;

    assign w_nm1  = CW'(i_n - NW'(1));
    assign w_nm2  = CW'(i_n - NW'(2));
    assign o_last = (r_i == w_nm2) && (r_j == w_nm1);
    assign o_i    = r_i;
    assign o_j    = r_j;

    // Index walker: rewind to (0,1) while idle, step one pair per advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_clear) begin
            r_i <= '0;
            r_j <= CW'(1);
        end else if (i_adv) begin
            if (r_j == w_nm1) begin
                r_i <= r_i + CW'(1);
                r_j <= r_i + CW'(2);
            end else begin
                r_j <= r_j + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pairwise_cmp_seq.sv
// Sequential k-out-of-n voter: one pairwise equality compare per cycle.
// Counts agreeing copies per dataset and reports the lowest-index winner.
module pairwise_cmp_seq
    import pairwise_cmp_pkg::*;
#(
    parameter int N_MAX = N_MAX_DEF,
    parameter int DW    = DW_DEF,
    localparam int CW = $clog2(N_MAX),
    localparam int NW = $clog2(N_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NW-1:0]       n_active,
    input  logic [NW-1:0]       threshold,
    input  logic [N_MAX*DW-1:0] sets,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [N_MAX*CW-1:0] match_cnt,
    output logic                winner_valid,
    output logic [CW-1:0]       winner_idx
);

    state_t        r_state;
    logic [DW-1:0] r_sets [N_MAX];
    logic [CW-1:0] r_cnt  [N_MAX];
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_thr;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_wv;
    logic [CW-1:0] r_widx;

    logic [CW-1:0] w_i;
    logic [CW-1:0] w_j;
    logic          w_last;
    logic          w_eq;
    logic          w_cfg_ok;
    logic          w_clear;
    logic          w_adv;
    logic [CW-1:0] w_cnt_nxt [N_MAX];
    logic          w_win_v;
    logic [CW-1:0] w_win_idx;

    assign w_cfg_ok = (n_active >= NW'(2)) && (n_active <= NW'(N_MAX))
                   && (threshold >= NW'(1)) && (threshold <= n_active);
    assign w_clear  = (r_state == S_IDLE);
    assign w_adv    = (r_state == S_RUN);

    pair_seq #(.N_MAX(N_MAX)) u_pair_seq (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_adv   (w_adv),
        .i_n     (r_n),
        .o_i     (w_i),
        .o_j     (w_j),
        .o_last  (w_last)
    );

    // Counts after this cycle's compare, so the winner sees the last pair.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_eq      = (r_sets[w_i] == r_sets[w_j]);
        if ((r_state == S_RUN) && w_eq) begin
            w_cnt_nxt[w_i] = r_cnt[w_i] + CW'(1);
            w_cnt_nxt[w_j] = r_cnt[w_j] + CW'(1);
        end
    end

    // Lowest active index whose copy count (self included) meets threshold.
    always_comb begin
        w_win_v   = 1'b0;
        w_win_idx = '0;
        for (int k = N_MAX - 1; k >= 0; k--) begin
            if ((NW'(k) < r_n)
                && ((NW'(w_cnt_nxt[k]) + NW'(1)) >= r_thr)) begin
                w_win_v   = 1'b1;
                w_win_idx = CW'(k);
            end
        end
    end

    // Control FSM: capture on start, compare pairs, publish on the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wv    <= 1'b0;
            r_widx  <= '0;
            r_n     <= '0;
            r_thr   <= '0;
            for (int k = 0; k < N_MAX; k++) begin
                r_sets[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < N_MAX; k++) begin
                            r_cnt[k] <= '0;
                        end
                        r_wv   <= 1'b0;
                        r_widx <= '0;
                        if (w_cfg_ok) begin
                            for (int k = 0; k < N_MAX; k++) begin
                                r_sets[k] <= sets[k*DW +: DW];
                            end
                            r_n     <= n_active;
                            r_thr   <= threshold;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_wv    <= w_win_v;
                        r_widx  <= w_win_idx;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_MAX; g++) begin : g_cnt
        assign match_cnt[g*CW +: CW] = r_cnt[g];
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign winner_valid = r_wv;
    assign winner_idx   = r_widx;

endmodule

// File: tb/tb_pairwise_cmp_seq.sv
// Self-checking bench for pairwise_cmp_seq: behavioural vote model,
// per-cycle output compare, directed corner cases and random votes.
module tb_pairwise_cmp_seq;

    localparam int N   = 9;
    localparam int DW  = 64;
    localparam int CW  = $clog2(N);
    localparam int NW  = $clog2(N + 1);
    localparam int N2  = 16;
    localparam int DW2 = 8;
    localparam int CW2 = $clog2(N2);
    localparam int NW2 = $clog2(N2 + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [NW-1:0]   n_active = '0;
    logic [NW-1:0]   threshold = '0;
    logic [N*DW-1:0] sets = '0;
    logic            busy, done, err, winner_valid;
    logic [N*CW-1:0] match_cnt;
    logic [CW-1:0]   winner_idx;

    logic              s_start = 1'b0;
    logic [NW2-1:0]    s_n = '0;
    logic [NW2-1:0]    s_thr = '0;
    logic [N2*DW2-1:0] s_sets = '0;
    logic              s_busy, s_done, s_err, s_wv;
    logic [N2*CW2-1:0] s_cnt;
    logic [CW2-1:0]    s_wi;

    pairwise_cmp_seq #(.N_MAX(N), .DW(DW)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .n_active(n_active), .threshold(threshold), .sets(sets),
        .busy(busy), .done(done), .err(err), .match_cnt(match_cnt),
        .winner_valid(winner_valid), .winner_idx(winner_idx)
    );

    pairwise_cmp_seq #(.N_MAX(N2), .DW(DW2)) u_dut16 (
        .clk(clk), .reset(reset), .start(s_start),
        .n_active(s_n), .threshold(s_thr), .sets(s_sets),
        .busy(s_busy), .done(s_done), .err(s_err), .match_cnt(s_cnt),
        .winner_valid(s_wv), .winner_idx(s_wi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pcnt = 0;
    bit mon = 1'b0;
    int exp_cnt [16];
    int exp_wv = 0;
    int exp_wi = 0;
    int exp_err = 0;
    int done_at = -1;
    int busy_lo = 1;
    int busy_hi = 0;
    int res_from = 0;

    always @(posedge clk) pcnt++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, pcnt);
        end
    endtask

    // Reference vote computed straight from the pair/threshold rules.
    task automatic model(input int n, input int thr, input logic [63:0] v [16]);
        bit ok;
        ok = (n >= 2) && (n <= N) && (thr >= 1) && (thr <= n);
        for (int k = 0; k < 16; k++) exp_cnt[k] = 0;
        exp_wv = 0;
        exp_wi = 0;
        exp_err = ok ? 0 : 1;
        if (ok) begin
            for (int a = 0; a < n; a++)
                for (int b = a + 1; b < n; b++)
                    if (v[a] == v[b]) begin
                        exp_cnt[a]++;
                        exp_cnt[b]++;
                    end
            for (int k = n - 1; k >= 0; k--)
                if (exp_cnt[k] + 1 >= thr) begin
                    exp_wv = 1;
                    exp_wi = k;
                end
        end
    endtask

    // Every cycle: done/busy timing, and held results once the vote is over.
    always @(negedge clk) begin
        if (mon) begin
            chk("done", done, pcnt == done_at);
            chk("busy", busy, (pcnt >= busy_lo) && (pcnt <= busy_hi));
            if (pcnt >= res_from) begin
                for (int k = 0; k < N; k++)
                    chk($sformatf("cnt%0d", k), match_cnt[k*CW +: CW], exp_cnt[k]);
                chk("winner_valid", winner_valid, exp_wv);
                chk("winner_idx", winner_idx, exp_wi);
                chk("err", err, exp_err);
            end
        end
    end

    task automatic rand_sets();
        for (int k = 0; k < N; k++) sets[k*DW +: DW] = {$urandom, $urandom};
        n_active = NW'($urandom_range(0, 15));
        threshold = NW'($urandom_range(0, 15));
    endtask

    task automatic run_vote(input int n, input int thr, input logic [63:0] v [16],
                            input bit hold, input int abort, output int lat);
        int n0;
        int p;
        @(posedge clk);
        #1;
        n0 = pcnt;
        n_active = NW'(n);
        threshold = NW'(thr);
        for (int k = 0; k < N; k++) sets[k*DW +: DW] = v[k];
        start = 1'b1;
        model(n, thr, v);
        p = exp_err ? 0 : n * (n - 1) / 2;
        done_at = n0 + 1 + p;
        busy_lo = exp_err ? 1 : n0 + 1;
        busy_hi = exp_err ? 0 : n0 + p;
        res_from = done_at;
        lat = -1;
        for (int c = 1; c <= p + 4; c++) begin
            @(posedge clk);
            #1;
            start = hold && (c <= p + 1);
            rand_sets();
            if (done && lat < 0) lat = pcnt - n0;
            if (abort != 0 && c == abort) begin
                start = 1'b0;
                reset = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_wv", winner_valid, 0);
                chk("rst_wi", winner_idx, 0);
                chk("rst_cnt", match_cnt, 0);
                for (int k = 0; k < 16; k++) exp_cnt[k] = 0;
                exp_wv = 0;
                exp_wi = 0;
                exp_err = 0;
                done_at = -1;
                busy_hi = 0;
                res_from = 0;
                reset = 1'b0;
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] v [16];
        int lat;
        int n;
        int thr;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_cnt", match_cnt, 0);
        chk("reset_wv", winner_valid, 0);
        chk("reset_wi", winner_idx, 0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) exp_cnt[k] = 0;
        mon = 1'b1;

        for (int k = 0; k < 16; k++) v[k] = 64'(1000 + k);
        v[0] = 64'd5; v[1] = 64'd5; v[2] = 64'd7;
        run_vote(3, 2, v, 1'b0, 0, lat);
        chk("lat_2oo3", lat, 4);
        chk("model_2oo3_cnt0", exp_cnt[0], 1);
        chk("model_2oo3_cnt2", exp_cnt[2], 0);
        chk("2oo3_cnt0", match_cnt[0 +: CW], 1);
        chk("2oo3_cnt1", match_cnt[CW +: CW], 1);
        chk("2oo3_cnt2", match_cnt[2*CW +: CW], 0);
        chk("2oo3_wv", winner_valid, 1);
        chk("2oo3_wi", winner_idx, 0);

        for (int k = 0; k < 16; k++) v[k] = 64'(200 + k);
        for (int k = 1; k <= 4; k++) v[k] = 64'hDEAD_BEEF_0000_0001;
        v[0] = 64'h5EAD_BEEF_0000_0001;
        run_vote(9, 5, v, 1'b0, 0, lat);
        chk("lat_5oo9", lat, 37);
        chk("model_5oo9_cnt4", exp_cnt[4], 3);
        chk("5oo9_cnt0", match_cnt[0 +: CW], 0);
        chk("5oo9_cnt1", match_cnt[CW +: CW], 3);
        chk("5oo9_cnt4", match_cnt[4*CW +: CW], 3);
        chk("5oo9_cnt8", match_cnt[8*CW +: CW], 0);
        chk("5oo9_wv", winner_valid, 0);

        run_vote(4, 0, v, 1'b0, 0, lat);
        chk("lat_thr0", lat, 1);
        chk("thr0_err", err, 1);
        chk("thr0_cnt", match_cnt, 0);
        run_vote(1, 1, v, 1'b0, 0, lat);
        chk("lat_n1", lat, 1);
        chk("n1_err", err, 1);
        run_vote(10, 3, v, 1'b0, 0, lat);
        chk("n10_err", err, 1);
        run_vote(3, 4, v, 1'b0, 0, lat);
        chk("thr_gt_n_err", err, 1);

        v[0] = 64'd9; v[1] = 64'd9;
        run_vote(2, 2, v, 1'b0, 0, lat);
        chk("lat_2oo2", lat, 2);
        chk("2oo2_err", err, 0);
        chk("2oo2_wv", winner_valid, 1);

        for (int k = 0; k < 16; k++) v[k] = 64'(k % 3);
        run_vote(7, 4, v, 1'b0, 5, lat);
        run_vote(7, 4, v, 1'b0, 0, lat);
        chk("lat_4oo7", lat, 22);
        chk("model_4oo7_cnt0", exp_cnt[0], 2);

        for (int k = 0; k < 16; k++) v[k] = 64'(300 + k);
        v[0] = 64'd5; v[1] = 64'd5; v[2] = 64'd7;
        run_vote(3, 2, v, 1'b1, 0, lat);
        chk("hold_lat", lat, 4);
        chk("hold_cnt0", match_cnt[0 +: CW], 1);
        chk("hold_cnt2", match_cnt[2*CW +: CW], 0);

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 11);
            thr = $urandom_range(0, n + 1);
            if ($urandom_range(0, 3) != 0) begin
                n = $urandom_range(2, N);
                thr = $urandom_range(1, n);
            end
            for (int k = 0; k < 16; k++)
                v[k] = {32'($urandom_range(0, 1)), 32'($urandom_range(0, 2))};
            run_vote(n, thr, v, $urandom_range(0, 3) == 0, 0, lat);
        end

        @(posedge clk);
        #1;
        s_n = NW2'(16);
        s_thr = NW2'(9);
        for (int k = 0; k < N2; k++) s_sets[k*DW2 +: DW2] = 8'hA5;
        s_start = 1'b1;
        n = pcnt;
        lat = -1;
        for (int c = 1; c <= 130; c++) begin
            @(posedge clk);
            #1;
            s_start = 1'b0;
            for (int k = 0; k < N2; k++) s_sets[k*DW2 +: DW2] = 8'($urandom);
            if (s_done && lat < 0) lat = pcnt - n;
        end
        chk("lat_n16", lat, 121);
        for (int k = 0; k < N2; k++)
            chk($sformatf("n16_cnt%0d", k), s_cnt[k*CW2 +: CW2], 15);
        chk("n16_wv", s_wv, 1);
        chk("n16_wi", s_wi, 0);
        chk("n16_err", s_err, 0);
        chk("n16_busy", s_busy, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
